// File: rtl/sram_wbuf_init.sv
// sram_wbuf_init: front end for a 512x12 two-port masked SRAM macro.
// After reset the array is swept to zero, then read/write requests are served.
// Writes pass through a one-entry buffer; reads return one cycle after accept.
// Optional build macro SRAM_WBUF_FWD_EN: same-cycle same-address read-after-write
// forwarding per mask segment (write-first). Undefined: read-first behaviour.
module sram_wbuf_init #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9,
    parameter int WIDTH  = 12,
    parameter int SEG    = 2,
    parameter int SEG_W  = 6
) (
    input  logic              clock,
    input  logic              reset,
    output logic              init_done,
    input  logic              r_req_valid,
    output logic              r_req_ready,
    input  logic [ADDR_W-1:0] r_req_addr,
    output logic              r_resp_valid,
    output logic [WIDTH-1:0]  r_resp_data,
    input  logic              w_req_valid,
    output logic              w_req_ready,
    input  logic [ADDR_W-1:0] w_req_addr,
    input  logic [WIDTH-1:0]  w_req_data,
    input  logic [SEG-1:0]    w_req_mask,
    output logic              sram_R0_en,
    output logic [ADDR_W-1:0] sram_R0_addr,
    input  logic [WIDTH-1:0]  sram_R0_data,
    output logic              sram_W0_en,
    output logic [ADDR_W-1:0] sram_W0_addr,
    output logic [WIDTH-1:0]  sram_W0_data,
    output logic [SEG-1:0]    sram_W0_mask
);

    // state | meaning
    // INIT  | zero-sweep of every entry, requests not accepted
    // RUN   | serving reads and writes, terminal until reset
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [0:0]        state_q,    state_d;
    logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
    logic              w_en_q,     w_en_d;
    logic [ADDR_W-1:0] w_addr_q,   w_addr_d;
    logic [WIDTH-1:0]  w_data_q,   w_data_d;
    logic [SEG-1:0]    w_mask_q,   w_mask_d;
    logic              r_vld_q,    r_vld_d;

    logic              run;
    logic              r_fire;
    logic              w_fire;
    logic [SEG-1:0]    fwd_mask;
    logic [WIDTH-1:0]  fwd_data;

    assign run          = (state_q == ST_RUN);
    assign init_done    = run;
    assign r_req_ready  = run;
    assign w_req_ready  = run;
    assign r_fire       = r_req_valid && run;
    assign w_fire       = w_req_valid && run;

    assign sram_R0_en   = r_fire;
    assign sram_R0_addr = r_req_addr;

    // The write port is driven straight from the buffer registers, which also
    // carry the sweep writes so the macro sees clean registered timing.
    assign sram_W0_en   = w_en_q;
    assign sram_W0_addr = w_addr_q;
    assign sram_W0_data = w_data_q;
    assign sram_W0_mask = w_mask_q;
    assign r_resp_valid = r_vld_q;

    // Sequencing and write-buffer next-state: the sweep address stays one step
    // ahead in w_addr_d so that w_addr_q always equals init_cnt_q during INIT.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        w_en_d     = 1'b0;
        w_addr_d   = w_addr_q;
        w_data_d   = w_data_q;
        w_mask_d   = w_mask_q;
        r_vld_d    = r_fire;
        if (state_q == ST_INIT) begin
            if (init_cnt_q == LAST_ADDR) begin
                state_d = ST_RUN;
            end else begin
                init_cnt_d = init_cnt_q + ADDR_W'(1);
                w_en_d     = 1'b1;
                w_addr_d   = init_cnt_q + ADDR_W'(1);
                w_data_d   = '0;
                w_mask_d   = '1;
            end
        end else if (w_fire) begin
            w_en_d   = 1'b1;
            w_addr_d = w_req_addr;
            w_data_d = w_req_data;
            w_mask_d = w_req_mask;
        end
    end

    // Main state, sweep counter, write buffer and read-response valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            w_en_q     <= 1'b1;
            w_addr_q   <= '0;
            w_data_q   <= '0;
            w_mask_q   <= '1;
            r_vld_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            w_en_q     <= w_en_d;
            w_addr_q   <= w_addr_d;
            w_data_q   <= w_data_d;
            w_mask_q   <= w_mask_d;
            r_vld_q    <= r_vld_d;
        end
    end

`ifdef SRAM_WBUF_FWD_EN
    logic [SEG-1:0]   fwd_mask_q, fwd_mask_d;
    logic [WIDTH-1:0] fwd_data_q, fwd_data_d;

    // Capture the same-cycle same-address write so the read response is write-first.
    always_comb begin
        fwd_mask_d = '0;
        fwd_data_d = fwd_data_q;
        if (r_fire && w_fire && (r_req_addr == w_req_addr)) begin
            fwd_mask_d = w_req_mask;
            fwd_data_d = w_req_data;
        end
    end

    // Forwarding registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            fwd_mask_q <= '0;
            fwd_data_q <= '0;
        end else begin
            fwd_mask_q <= fwd_mask_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    assign fwd_mask = fwd_mask_q;
    assign fwd_data = fwd_data_q;
`else
    // Read-first: the array value is returned unmodified.
    assign fwd_mask = '0;
    assign fwd_data = '0;
`endif

    // Per-segment merge of forwarded write data over the array read data.
    always_comb begin
        r_resp_data = sram_R0_data;
        for (int i = 0; i < SEG; i++) begin
            if (fwd_mask[i]) begin
                r_resp_data[i*SEG_W +: SEG_W] = fwd_data[i*SEG_W +: SEG_W];
            end
        end
    end

endmodule

// File: tb/tb_sram_wbuf_init.sv
// Directed bench for sram_wbuf_init with a behavioural SRAM model and a
// read-response scoreboard.
module tb_sram_wbuf_init;

    logic        clock = 1'b0;
    logic        reset;
    logic        init_done;
    logic        r_req_valid;
    logic        r_req_ready;
    logic [8:0]  r_req_addr;
    logic        r_resp_valid;
    logic [11:0] r_resp_data;
    logic        w_req_valid;
    logic        w_req_ready;
    logic [8:0]  w_req_addr;
    logic [11:0] w_req_data;
    logic [1:0]  w_req_mask;
    logic        sram_R0_en;
    logic [8:0]  sram_R0_addr;
    logic [11:0] sram_R0_data;
    logic        sram_W0_en;
    logic [8:0]  sram_W0_addr;
    logic [11:0] sram_W0_data;
    logic [1:0]  sram_W0_mask;

    int          checks = 0;
    int          errors = 0;
    logic [11:0] exp_q[$];
    logic [11:0] mem [0:511];
    logic        def_seen = 1'b0;

    always #5 clock = ~clock;

    sram_wbuf_init dut (
        .clock        (clock),
        .reset        (reset),
        .init_done    (init_done),
        .r_req_valid  (r_req_valid),
        .r_req_ready  (r_req_ready),
        .r_req_addr   (r_req_addr),
        .r_resp_valid (r_resp_valid),
        .r_resp_data  (r_resp_data),
        .w_req_valid  (w_req_valid),
        .w_req_ready  (w_req_ready),
        .w_req_addr   (w_req_addr),
        .w_req_data   (w_req_data),
        .w_req_mask   (w_req_mask),
        .sram_R0_en   (sram_R0_en),
        .sram_R0_addr (sram_R0_addr),
        .sram_R0_data (sram_R0_data),
        .sram_W0_en   (sram_W0_en),
        .sram_W0_addr (sram_W0_addr),
        .sram_W0_data (sram_W0_data),
        .sram_W0_mask (sram_W0_mask)
    );

    // SRAM model: a write committing at an edge is visible to a read captured at that edge.
    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 12'h777;
        sram_R0_data = 12'h000;
    end

    always @(posedge clock) begin
        if (sram_W0_en) begin
            for (int s = 0; s < 2; s++)
                if (sram_W0_mask[s]) mem[sram_W0_addr][s*6 +: 6] = sram_W0_data[s*6 +: 6];
            if (sram_W0_addr == 9'h040 && sram_W0_data == 12'hDEF) def_seen = 1'b1;
        end
        if (sram_R0_en) sram_R0_data <= mem[sram_R0_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every presented response must match the oldest expectation.
    always @(negedge clock) begin
        if (r_resp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got %0h expected no response", r_resp_data);
            end else begin
                check("read_resp", 32'(r_resp_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_w(input logic [8:0] a, input logic [11:0] d, input logic [1:0] m);
        w_req_valid = 1'b1;
        w_req_addr  = a;
        w_req_data  = d;
        w_req_mask  = m;
    endtask

    task automatic set_r(input logic [8:0] a, input logic [11:0] e);
        r_req_valid = 1'b1;
        r_req_addr  = a;
        exp_q.push_back(e);
    endtask

    task automatic clr();
        r_req_valid = 1'b0;
        w_req_valid = 1'b0;
    endtask

    initial begin
        int bad;
        int rise;
        reset = 1'b1;
        r_req_valid = 1'b0; r_req_addr = '0;
        w_req_valid = 1'b0; w_req_addr = '0; w_req_data = '0; w_req_mask = '0;
        repeat (3) tick();
        @(negedge clock);
        check("rst_init_done", 32'(init_done), 0);
        check("rst_ready", 32'({r_req_ready, w_req_ready}), 0);
        check("rst_resp_valid", 32'(r_resp_valid), 0);
        check("rst_w0", 32'({sram_W0_en, sram_W0_addr, sram_W0_data, sram_W0_mask}),
              32'({1'b1, 9'h000, 12'h000, 2'b11}));
        tick();
        reset = 1'b0;

        // Zero sweep: cycles 0..511 write address == cycle.
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            @(negedge clock);
            if (!(sram_W0_en && sram_W0_addr == 9'(i) && sram_W0_data == 12'h000 &&
                  sram_W0_mask == 2'b11 && !init_done && !r_req_ready && !w_req_ready)) bad++;
        end
        check("sweep_bad_cycles", 32'(bad), 0);
        @(negedge clock);
        check("done_at_512", 32'(init_done), 1);
        check("ready_at_512", 32'({r_req_ready, w_req_ready}), 32'(2'b11));
        check("w0_idle_at_512", 32'(sram_W0_en), 0);
        tick();

        set_r(9'h1FF, 12'h000); tick();
        set_r(9'h000, 12'h000); tick(); clr(); tick();

        // Write then read on the following cycle.
        set_w(9'h005, 12'hABC, 2'b11); tick(); clr();
        set_r(9'h005, 12'hABC);
        @(negedge clock);
        check("wr_w0_en", 32'(sram_W0_en), 1);
        check("wr_w0_addr", 32'(sram_W0_addr), 32'h005);
        check("wr_w0_data", 32'(sram_W0_data), 32'hABC);
        check("wr_w0_mask", 32'(sram_W0_mask), 32'h3);
        tick(); clr(); tick();

        // Partial mask over a full write, back to back.
        set_w(9'h010, 12'hFFF, 2'b11); tick();
        set_w(9'h010, 12'h000, 2'b01); tick(); clr();
        set_r(9'h010, 12'hFC0); tick(); clr(); tick();

        // Same-cycle read-after-write.
        set_w(9'h020, 12'h555, 2'b11); tick(); clr(); tick();
        set_w(9'h020, 12'hAAA, 2'b10);
`ifdef SRAM_WBUF_FWD_EN
        set_r(9'h020, 12'hA95);
`else
        set_r(9'h020, 12'h555);
`endif
        tick(); clr(); tick();
        set_r(9'h020, 12'hA95); tick(); clr();

        // Independent read and write to different addresses.
        set_w(9'h030, 12'h123, 2'b11); set_r(9'h005, 12'hABC); tick(); clr();
        set_r(9'h030, 12'h123); tick(); clr();

        // Mask-zero write still strobes the port but leaves the entry alone.
        set_w(9'h005, 12'hFFF, 2'b00); tick(); clr();
        @(negedge clock);
        check("mask0_w0_en", 32'(sram_W0_en), 1);
        check("mask0_w0_mask", 32'(sram_W0_mask), 0);
        tick();
        set_r(9'h005, 12'hABC); tick(); clr();
        repeat (3) tick();
        check("queue_drained_run", 32'(exp_q.size()), 0);

        // Reset mid-run: write and read accepted in the cycle reset is sampled.
        set_w(9'h040, 12'hDEF, 2'b11); r_req_valid = 1'b1; r_req_addr = 9'h005;
        reset = 1'b1;
        tick(); reset = 1'b0; clr();
        @(negedge clock);
        check("rr_w0", 32'({sram_W0_en, sram_W0_addr, sram_W0_data, sram_W0_mask}),
              32'({1'b1, 9'h000, 12'h000, 2'b11}));
        check("rr_resp_valid", 32'(r_resp_valid), 0);
        check("rr_init_done", 32'(init_done), 0);
        check("rr_ready", 32'({r_req_ready, w_req_ready}), 0);

        // Reset mid-init at cycle 200 restarts the sweep.
        repeat (200) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        rise = -1;
        for (int k = 0; k <= 600; k++) begin
            @(negedge clock);
            if (k == 0) check("mi_restart_addr", 32'({sram_W0_en, sram_W0_addr}), 32'({1'b1, 9'h000}));
            if (init_done) begin
                rise = k;
                break;
            end
        end
        check("mi_done_cycle", 32'(rise), 512);
        tick();

        set_r(9'h005, 12'h000); tick();
        set_r(9'h040, 12'h000); tick(); clr();
        repeat (3) tick();
        check("queue_drained_end", 32'(exp_q.size()), 0);
        check("dropped_write_absent", 32'(def_seen), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
